// File: rtl/vend_pkg.sv
// Shared types for the vending change controller: coin codes, FSM states and
// the coin-to-unit conversion used by both the controller and the dispenser.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10,
        COIN_BAD  = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_e;

    // Value of a coin in 5 rs units; anything that is not a real coin is worth 0.
    function automatic logic [1:0] coin_units(coin_e c);
        case (c)
            COIN_5:  return 2'd1;
            COIN_10: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_ctrl_if.sv
// Customer-side and dispenser-side signals of the vending controller.
// master drives coins/requests and the dispenser ready; slave is the controller.
interface vend_change_ctrl_if #(
    parameter int CW = 3,
    parameter int SW = 4
);
    logic          coin_valid;
    logic [1:0]    coin;
    logic          cancel;
    logic          restock;
    logic          change_ready;
    logic          vend;
    logic          coin_reject;
    logic          change_valid;
    logic [1:0]    change_coin;
    logic [CW-1:0] credit;
    logic [SW-1:0] stock;
    logic          sold_out;
    logic          busy;

    modport master (
        output coin_valid, coin, cancel, restock, change_ready,
        input  vend, coin_reject, change_valid, change_coin, credit, stock, sold_out, busy
    );

    modport slave (
        input  coin_valid, coin, cancel, restock, change_ready,
        output vend, coin_reject, change_valid, change_coin, credit, stock, sold_out, busy
    );
endinterface

// File: rtl/vend_change_disp.sv
// Remainder counter and ready/valid coin dispenser: pays out 10 rs coins first,
// then a final 5 rs coin, one coin per accepted handshake.
module vend_change_disp
    import vend_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_units,
    input  logic          ready,
    output logic          valid,
    output logic [1:0]    coin,
    output logic          done
);

    logic [CW-1:0] rem_reg, rem_next;
    logic          valid_reg;
    coin_e         coin_reg, coin_next;
    logic          take;
    logic [CW-1:0] step;

    always_comb begin
        take     = valid_reg && ready;
        step     = CW'(coin_units(coin_reg));
        rem_next = rem_reg;
        if (load) begin
            rem_next = load_units;
        end else if (take) begin
            rem_next = rem_reg - step;
        end
        // The coin shown next cycle is chosen from the updated remainder so it is registered.
        coin_next = COIN_NONE;
        if (rem_next >= CW'(2)) begin
            coin_next = COIN_10;
        end else if (rem_next != '0) begin
            coin_next = COIN_5;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg   <= '0;
            valid_reg <= 1'b0;
            coin_reg  <= COIN_NONE;
        end else begin
            rem_reg   <= rem_next;
            valid_reg <= (rem_next != '0);
            coin_reg  <= coin_next;
        end
    end

    assign valid = valid_reg;
    assign coin  = coin_reg;
    assign done  = take && (rem_reg == step);

endmodule

// File: rtl/vend_change_ctrl.sv
// Parametrised vending controller: accumulates 5/10 rs coins against PRICE,
// pulses vend, returns change or refunded credit through the coin dispenser.
module vend_change_ctrl
    import vend_pkg::*;
#(
    parameter  int PRICE      = 3,
    parameter  int MAX_CREDIT = 4,
    parameter  int STOCK_INIT = 8,
    localparam int CW         = $clog2(MAX_CREDIT + 1),
    localparam int SW         = $clog2(STOCK_INIT + 1)
) (
    input logic               clk,
    input logic               rst,
    vend_change_ctrl_if.slave bus
);

    state_e        state_reg, state_next;
    logic [CW-1:0] credit_reg, credit_next;
    logic [SW-1:0] stock_reg, stock_next;
    logic          vend_reg, vend_next;
    logic          reject_reg, reject_next;
    logic          load;
    logic [CW-1:0] load_units;
    logic          disp_done;
    coin_e         coin_in;
    logic          coin_ok;

    assign coin_in = coin_e'(bus.coin);
    assign coin_ok = (coin_in == COIN_5) || (coin_in == COIN_10);

    always_comb begin
        state_next  = state_reg;
        credit_next = credit_reg;
        stock_next  = stock_reg;
        vend_next   = 1'b0;
        reject_next = 1'b0;
        load        = 1'b0;
        load_units  = '0;
        case (state_reg)
            COLLECT: begin
                if (bus.cancel) begin
                    // Cancel wins: any coin offered alongside it goes straight back.
                    reject_next = bus.coin_valid;
                    if (credit_reg != '0) begin
                        load        = 1'b1;
                        load_units  = credit_reg;
                        credit_next = '0;
                        state_next  = CHANGE;
                    end
                end else if (bus.coin_valid) begin
                    if (!coin_ok || (stock_reg == '0)) begin
                        reject_next = 1'b1;
                    end else begin
                        credit_next = credit_reg + CW'(coin_units(coin_in));
                        if (credit_next >= CW'(PRICE)) begin
                            state_next = VEND;
                        end
                    end
                end
            end
            VEND: begin
                vend_next   = 1'b1;
                reject_next = bus.coin_valid;
                stock_next  = stock_reg - SW'(1);
                load        = 1'b1;
                load_units  = credit_reg - CW'(PRICE);
                credit_next = '0;
                state_next  = (load_units != '0) ? CHANGE : COLLECT;
            end
            CHANGE: begin
                reject_next = bus.coin_valid;
                if (disp_done) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
        if (bus.restock) begin
            stock_next = SW'(STOCK_INIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= COLLECT;
            credit_reg <= '0;
            stock_reg  <= SW'(STOCK_INIT);
            vend_reg   <= 1'b0;
            reject_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            credit_reg <= credit_next;
            stock_reg  <= stock_next;
            vend_reg   <= vend_next;
            reject_reg <= reject_next;
        end
    end

    vend_change_disp #(
        .CW(CW)
    ) u_disp (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_units (load_units),
        .ready      (bus.change_ready),
        .valid      (bus.change_valid),
        .coin       (bus.change_coin),
        .done       (disp_done)
    );

    assign bus.vend        = vend_reg;
    assign bus.coin_reject = reject_reg;
    assign bus.credit      = credit_reg;
    assign bus.stock       = stock_reg;
    assign bus.sold_out    = (stock_reg == '0);
    assign bus.busy        = (state_reg != COLLECT);

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Self-checking bench for vend_change_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a credit/coin-queue model.
module tb_vend_change_ctrl;

    localparam int PRICE = 3;
    localparam int STOCK0 = 8;

    logic clk;
    logic rst0, rst1;
    int   total, passed;

    vend_change_ctrl_if #(.CW(3), .SW(4)) b0 ();
    vend_change_ctrl_if #(.CW(3), .SW(1)) b1 ();

    vend_change_ctrl #(.PRICE(PRICE), .MAX_CREDIT(4), .STOCK_INIT(STOCK0)) d0 (
        .clk(clk), .rst(rst0), .bus(b0)
    );
    vend_change_ctrl #(.PRICE(PRICE), .MAX_CREDIT(5), .STOCK_INIT(1)) d1 (
        .clk(clk), .rst(rst1), .bus(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int credit;
        int vend;
        int rej;
        int cvld;
        int cc;
        int busy;
        int stock;
    } exp_t;

    typedef struct {
        logic       cv;
        logic [1:0] coin;
        logic       cancel;
        logic       restock;
        logic       ready;
        exp_t       e;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: credit in units, items left, a pending vend and
    // the list of coins still owed to the customer (front = coin on display).
    int m_credit, m_stock, m_vend, m_rej;
    bit m_in_vend;
    int m_q[$];

    function automatic exp_t mk(int credit, int vend, int rej, int cvld, int cc, int busy, int stock);
        exp_t e;
        e.credit = credit; e.vend = vend; e.rej = rej; e.cvld = cvld;
        e.cc = cc; e.busy = busy; e.stock = stock;
        return e;
    endfunction

    task automatic add(logic cv, logic [1:0] coin, logic cancel, logic restock, logic ready,
                       int credit, int vend, int rej, int cvld, int cc, int busy, int stock);
        vec_t v;
        v.cv = cv; v.coin = coin; v.cancel = cancel; v.restock = restock; v.ready = ready;
        v.e = mk(credit, vend, rej, cvld, cc, busy, stock);
        vecs.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic cmp_all(string tag, exp_t e, logic vend, logic rej, logic cvld, logic [1:0] cc,
                           logic [7:0] credit, logic [7:0] stock, logic sold, logic busy);
        chk({tag, ".credit"}, 32'(credit), 32'(e.credit));
        chk({tag, ".vend"}, 32'(vend), 32'(e.vend));
        chk({tag, ".coin_reject"}, 32'(rej), 32'(e.rej));
        chk({tag, ".change_valid"}, 32'(cvld), 32'(e.cvld));
        chk({tag, ".change_coin"}, 32'(cc), 32'(e.cc));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".stock"}, 32'(stock), 32'(e.stock));
        chk({tag, ".sold_out"}, 32'(sold), 32'(e.stock == 0));
    endtask

    task automatic check0(string tag, exp_t e);
        cmp_all(tag, e, b0.vend, b0.coin_reject, b0.change_valid, b0.change_coin,
                8'(b0.credit), 8'(b0.stock), b0.sold_out, b0.busy);
    endtask

    task automatic check1(string tag, exp_t e);
        cmp_all(tag, e, b1.vend, b1.coin_reject, b1.change_valid, b1.change_coin,
                8'(b1.credit), 8'(b1.stock), b1.sold_out, b1.busy);
    endtask

    task automatic drive0(logic cv, logic [1:0] coin, logic cancel, logic restock, logic ready);
        b0.coin_valid = cv; b0.coin = coin; b0.cancel = cancel;
        b0.restock = restock; b0.change_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(logic cv, logic [1:0] coin, logic cancel, logic restock, logic ready);
        b1.coin_valid = cv; b1.coin = coin; b1.cancel = cancel;
        b1.restock = restock; b1.change_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic owe(int units);
        int r;
        r = units;
        while (r >= 2) begin
            m_q.push_back(2);
            r -= 2;
        end
        if (r == 1) m_q.push_back(1);
    endtask

    // One clock edge of the machine as the rules describe it.
    task automatic model_step(logic cv, logic [1:0] coin, logic cancel, logic restock, logic ready);
        int units;
        units = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : 0;
        m_vend = 0;
        m_rej  = 0;
        if (m_in_vend) begin
            m_vend = 1;
            m_rej  = cv;
            m_stock -= 1;
            owe(m_credit - PRICE);
            m_credit  = 0;
            m_in_vend = 0;
        end else if (m_q.size() > 0) begin
            m_rej = cv;
            if (ready) void'(m_q.pop_front());
        end else if (cancel) begin
            m_rej = cv;
            if (m_credit > 0) begin
                owe(m_credit);
                m_credit = 0;
            end
        end else if (cv) begin
            if (units == 0 || m_stock == 0) m_rej = 1;
            else begin
                m_credit += units;
                if (m_credit >= PRICE) m_in_vend = 1;
            end
        end
        if (restock) m_stock = STOCK0;
    endtask

    function automatic exp_t model_exp();
        int cvld;
        cvld = (m_q.size() > 0) ? 1 : 0;
        return mk(m_credit, m_vend, m_rej, cvld, cvld ? m_q[0] : 0,
                  (m_in_vend || cvld) ? 1 : 0, m_stock);
    endfunction

    initial begin
        total = 0;
        passed = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        b1.coin_valid = 0; b1.coin = 0; b1.cancel = 0; b1.restock = 0; b1.change_ready = 0;
        drive0(0, 2'b00, 0, 0, 0);
        drive0(0, 2'b00, 0, 0, 0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        check0("reset0", mk(0, 0, 0, 0, 0, 0, STOCK0));
        check1("reset1", mk(0, 0, 0, 0, 0, 0, 1));

        // cv coin cancel restock ready | credit vend rej cvld cc busy stock
        add(1, 2'b01, 0, 0, 1,  1, 0, 0, 0, 0, 0, 8);  // 5,5,5 exact price
        add(1, 2'b01, 0, 0, 1,  2, 0, 0, 0, 0, 0, 8);
        add(1, 2'b01, 0, 0, 1,  3, 0, 0, 0, 0, 1, 8);
        add(0, 2'b00, 0, 0, 1,  0, 1, 0, 0, 0, 0, 7);
        add(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0, 7);
        add(1, 2'b10, 0, 0, 0,  2, 0, 0, 0, 0, 0, 7);  // 10,10 -> one 5 back, slow dispenser
        add(1, 2'b10, 0, 0, 0,  4, 0, 0, 0, 0, 1, 7);
        add(0, 2'b00, 0, 0, 0,  0, 1, 0, 1, 1, 1, 6);
        add(0, 2'b00, 0, 0, 0,  0, 0, 0, 1, 1, 1, 6);
        add(0, 2'b00, 0, 0, 0,  0, 0, 0, 1, 1, 1, 6);
        add(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0, 6);
        add(1, 2'b01, 0, 0, 1,  1, 0, 0, 0, 0, 0, 6);  // 5,10 then 10 during VEND
        add(1, 2'b10, 0, 0, 1,  3, 0, 0, 0, 0, 1, 6);
        add(1, 2'b10, 0, 0, 1,  0, 1, 1, 0, 0, 0, 5);
        add(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0, 5);
        add(1, 2'b01, 0, 0, 1,  1, 0, 0, 0, 0, 0, 5);  // credit 2 then cancel + 10
        add(1, 2'b01, 0, 0, 1,  2, 0, 0, 0, 0, 0, 5);
        add(1, 2'b10, 1, 0, 0,  0, 0, 1, 1, 2, 1, 5);
        add(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, 0, 5);
        add(0, 2'b00, 0, 1, 1,  0, 0, 0, 0, 0, 0, 8);  // restock
        add(1, 2'b11, 0, 0, 1,  0, 0, 1, 0, 0, 0, 8);  // bad codes
        add(1, 2'b00, 0, 0, 1,  0, 0, 1, 0, 0, 0, 8);
        add(0, 2'b00, 1, 0, 1,  0, 0, 0, 0, 0, 0, 8);  // cancel with no credit
        for (int i = 0; i < vecs.size(); i++) begin
            drive0(vecs[i].cv, vecs[i].coin, vecs[i].cancel, vecs[i].restock, vecs[i].ready);
            check0($sformatf("vec%0d", i), vecs[i].e);
        end

        // Single-item machine: sell out, reject, restock, accept again.
        drive1(1, 2'b01, 0, 0, 1); check1("so.c5", mk(1, 0, 0, 0, 0, 0, 1));
        drive1(1, 2'b10, 0, 0, 1); check1("so.c10", mk(3, 0, 0, 0, 0, 1, 1));
        drive1(0, 2'b00, 0, 0, 1); check1("so.vend", mk(0, 1, 0, 0, 0, 0, 0));
        drive1(1, 2'b01, 0, 0, 1); check1("so.rej", mk(0, 0, 1, 0, 0, 0, 0));
        drive1(0, 2'b00, 0, 1, 1); check1("so.restock", mk(0, 0, 0, 0, 0, 0, 1));
        drive1(1, 2'b01, 0, 0, 1); check1("so.accept", mk(1, 0, 0, 0, 0, 0, 1));

        // Randomized traffic against the model.
        rst0 = 1'b1;
        drive0(0, 2'b00, 0, 0, 0);
        rst0 = 1'b0;
        m_credit = 0; m_stock = STOCK0; m_in_vend = 0; m_q.delete();
        for (int n = 0; n < 600; n++) begin
            logic cv, cancel, restock, ready;
            logic [1:0] coin;
            int r;
            r = $urandom_range(0, 9);
            coin    = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
            cv      = ($urandom_range(0, 9) < 5);
            cancel  = ($urandom_range(0, 19) == 0);
            restock = ($urandom_range(0, 39) == 0);
            ready   = ($urandom_range(0, 1) == 1);
            model_step(cv, coin, cancel, restock, ready);
            drive0(cv, coin, cancel, restock, ready);
            check0($sformatf("rnd%0d", n), model_exp());
        end

        // Reset in the middle of a refund discards the pending change.
        rst0 = 1'b1;
        drive0(0, 2'b00, 0, 0, 0);
        rst0 = 1'b0;
        drive0(1, 2'b01, 0, 0, 0);
        drive0(1, 2'b01, 0, 0, 0);
        drive0(0, 2'b00, 1, 0, 0); check0("rstmid.change", mk(0, 0, 0, 1, 2, 1, STOCK0));
        rst0 = 1'b1;
        drive0(0, 2'b00, 0, 0, 0); check0("rstmid.clear", mk(0, 0, 0, 0, 0, 0, STOCK0));
        rst0 = 1'b0;
        drive0(1, 2'b11, 0, 0, 0); check0("rstmid.bad", mk(0, 0, 1, 0, 0, 0, STOCK0));
        drive0(0, 2'b00, 0, 0, 0); check0("rstmid.idle", mk(0, 0, 0, 0, 0, 0, STOCK0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vend_change_ctrl.md
Name: vend_change_ctrl

Overview:
- Parametrised vending controller; successor to the fixed 15 rs, two-coin machine.
- Accumulates 5/10 rs coins against a configurable price and issues a one-cycle vend pulse.
- Returns the remainder or a cancelled credit through a ready/valid coin-dispenser handshake, one coin per handshake.
- Tracks stock, blocks sales when empty, and reports the live credit.

Parameters:
- PRICE, 3, item price in 5 rs units (3 = 15 rs); must be >= 1.
- MAX_CREDIT, 4, credit register ceiling in units; must be >= PRICE+1 so a 10 rs coin never overflows.
- STOCK_INIT, 8, items loaded at reset and on restock; must be >= 1.
- CW, $clog2(MAX_CREDIT+1), credit width (derived, not overridden).
- SW, $clog2(STOCK_INIT+1), stock width (derived, not overridden).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- coin_valid  in  1  coin present this cycle.
- coin  in  2  coin code: 01 = 5 rs, 10 = 10 rs; 00 and 11 are invalid.
- cancel  in  1  request refund of current credit.
- restock  in  1  reload stock to STOCK_INIT.
- change_ready  in  1  dispenser accepts the coin on change_coin.
- vend  out  1  one-cycle pulse, one item dispensed.
- coin_reject  out  1  one-cycle pulse, the coin offered this cycle is returned unused.
- change_valid  out  1  change_coin holds a coin to dispense.
- change_coin  out  2  coin being returned: 01 = 5 rs, 10 = 10 rs; 00 when change_valid is low.
- credit  out  CW  current credit in units.
- stock  out  SW  items remaining.
- sold_out  out  1  stock == 0.
- busy  out  1  state != COLLECT.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=COLLECT, credit=0, remainder=0, stock=STOCK_INIT.
  - vend, coin_reject, change_valid and change_coin are 0; sold_out=0.
  - rst overrides everything mid-operation: pending change is discarded and no vend is issued.
- All outputs are registered; vend and coin_reject are high for exactly one cycle.
- COLLECT:
  - A valid coin with stock>0 and cancel=0 adds 1 or 2 units to credit at the next edge.
  - If the new credit >= PRICE, go to VEND.
  - coin_reject pulses next cycle for any of: invalid code, sold_out, or cancel asserted in the same cycle. Cancel wins over a simultaneous coin.
  - cancel with credit>0: remainder<=credit, credit<=0, go to CHANGE.
  - cancel with credit==0: ignored.
- VEND (one cycle):
  - vend=1, stock decrements, remainder<=credit-PRICE, credit<=0.
  - Go to CHANGE if remainder>0, else COLLECT.
- CHANGE:
  - change_valid=1.
  - change_coin=10 if remainder>=2, else 01.
  - On change_valid && change_ready, subtract the coin value from remainder. When the result is 0, deassert change_valid and return to COLLECT on that edge.
  - change_coin is held stable while change_ready=0. No timeout.
- Coins offered in VEND or CHANGE: coin_reject pulse, credit unchanged. cancel in VEND or CHANGE: ignored.
- restock: loads stock=STOCK_INIT in any state. If it coincides with the VEND decrement, restock wins (result STOCK_INIT).
- sold_out is combinational from the stock register. credit is the register value.
- Latency:
  - Coin to credit update: 1 cycle.
  - Price-reaching coin to vend pulse: 2 cycles (COLLECT→VEND edge, vend registered in VEND).

Decomposition:
- Package vend_pkg:
  - coin_e (COIN_NONE=00, COIN_5=01, COIN_10=10, COIN_BAD=11).
  - state_e (COLLECT, VEND, CHANGE).
  - function coin_units(coin_e) returning 0/1/2.
- One sub-module: vend_change_disp, the remainder counter plus the ready/valid change handshake, loaded from the top FSM.

Test Plan:
- PRICE=3. Coins 5,5,5 back to back → credit 1,2,3; vend pulse on cycle 4; change_valid never asserted; stock 8→7.
- PRICE=3. Coins 10,10 → credit 2 then VEND; remainder 1; change_coin=01 held for 3 cycles while change_ready=0, then one handshake → COLLECT, busy=0.
- PRICE=3, MAX_CREDIT=5, coins 5 then 10 then 10 (second 10 during VEND) → second 10 gets coin_reject; vend once; no change.
- Credit 2 (two 5s), then cancel with a simultaneous 10 coin → coin_reject pulse; change_coin=10 once; credit 0; no vend.
- STOCK_INIT=1: one sale → sold_out=1; next coin rejected; restock → stock=1, sold_out=0; coin accepted.
- Credit 2, rst mid-CHANGE with change_ready=0 → next cycle all outputs 0, credit 0, stock retains STOCK_INIT; invalid code 11 → coin_reject only.
